// File: rtl/ref_window_server_if.sv
// Handshake bundle for the reference-window server: buffer write port,
// request channel and tap-set output stream.
interface ref_window_server_if;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_idx;
  logic        req_dir;
  logic        out_valid;
  logic        out_ready;
  logic [47:0] out_pix;
  logic        out_last;

  modport master (
    output wr_en, wr_addr, wr_data, req_valid, req_idx, req_dir, out_ready,
    input  req_ready, out_valid, out_pix, out_last
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, req_valid, req_idx, req_dir, out_ready,
    output req_ready, out_valid, out_pix, out_last
  );
endinterface

// File: rtl/ref_window_server.sv
// Reference-pixel responder for FME half-pel interpolation: 16x16 block buffer
// streaming LINES six-tap pixel sets per request with edge replication.

// One tap position: computes the clamped buffer address of tap K on a line.
module ref_tap_lane #(
  parameter int K = 0
) (
  input  logic [3:0] row,
  input  logic [3:0] col,
  input  logic       dir,
  input  logic [2:0] line,
  output logic [7:0] addr
);
  logic [5:0] r_raw, c_raw;

  // Range is -2..20, so bit5 flags negative and bit4 flags beyond the block.
  function automatic logic [3:0] clamp4(input logic [5:0] v);
    if (v[5])      return 4'd0;
    else if (v[4]) return 4'hf;
    else           return v[3:0];
  endfunction

  always_comb begin
    r_raw = {2'b00, row} + (dir ? 6'(K) : {3'b000, line}) - 6'd2;
    c_raw = {2'b00, col} + (dir ? {3'b000, line} : 6'(K)) - 6'd2;
  end

  assign addr = {clamp4(r_raw), clamp4(c_raw)};
endmodule

module ref_window_server #(
  parameter int LINES = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  ref_window_server_if.slave   bus
);
  localparam int TAPS = 6;
  localparam logic [2:0] LAST = 3'(LINES - 1);

  typedef enum logic {IDLE, STREAM} state_t;
  typedef struct packed {
    logic [3:0] row;
    logic [3:0] col;
    logic       dir;
  } req_t;

  logic [7:0] mem [256];

  state_t state, state_nxt;
  req_t   cur, fetch;
  logic [2:0] j, fetch_j;
  logic [TAPS-1:0][7:0] tap_addr, tap_pix;
  logic accept, advance, finish;

  assign accept  = bus.req_valid & bus.req_ready;
  assign advance = (state == STREAM) & bus.out_ready & (j != LAST);
  assign finish  = (state == STREAM) & bus.out_ready & (j == LAST);

  // Buffer is not reset; reads below see pre-edge contents on a collision.
  always_ff @(posedge clk)
    if (bus.wr_en) mem[bus.wr_addr] <= bus.wr_data;

  // Line 0 comes from the live request, later lines from the latched one.
  always_comb begin
    fetch   = cur;
    fetch_j = 3'(j + 3'd1);
    if (accept) begin
      fetch   = '{row: bus.req_idx[7:4], col: bus.req_idx[3:0], dir: bus.req_dir};
      fetch_j = 3'd0;
    end
  end

  for (genvar k = 0; k < TAPS; k++) begin : g_lane
    ref_tap_lane #(.K(k)) u_lane (
      .row  (fetch.row),
      .col  (fetch.col),
      .dir  (fetch.dir),
      .line (fetch_j),
      .addr (tap_addr[k])
    );
    assign tap_pix[k] = mem[tap_addr[k]];
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else      state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = STREAM;
      STREAM:  if (finish) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = (state == IDLE);
    bus.out_valid = (state == STREAM);
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cur          <= '0;
      j            <= '0;
      bus.out_pix  <= '0;
      bus.out_last <= 1'b0;
    end else if (accept) begin
      cur          <= fetch;
      j            <= 3'd0;
      bus.out_pix  <= tap_pix;
      bus.out_last <= (LINES == 1);
    end else if (advance) begin
      j            <= fetch_j;
      bus.out_pix  <= tap_pix;
      bus.out_last <= (fetch_j == LAST);
    end else if (finish) begin
      j            <= 3'd0;
      bus.out_last <= 1'b0;
    end
endmodule

// File: tb/tb_ref_window_server.sv
// Directed scoreboard bench for ref_window_server: model-predicted tap-sets
// are queued at request time and popped as beats are accepted.
module tb_ref_window_server;
  localparam int LINES = 6;

  typedef struct {
    logic [47:0] pix;
    logic        last;
  } beat_t;

  logic clk, rst;
  ref_window_server_if bus ();

  ref_window_server #(.LINES(LINES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [7:0]  ref_mem [256];
  logic [47:0] seen    [8];
  beat_t exp_q [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic int clampi(input int v);
    return (v < 0) ? 0 : ((v > 15) ? 15 : v);
  endfunction

  function automatic logic [47:0] model(input int idx, input int dir, input int j);
    logic [47:0] res;
    int row, col, r, c;
    row = idx / 16;
    col = idx % 16;
    res = '0;
    for (int k = 0; k < 6; k++) begin
      r = clampi(dir ? row + k - 2 : row + j - 2);
      c = clampi(dir ? col + j - 2 : col + k - 2);
      res[8*k +: 8] = ref_mem[r*16 + c];
    end
    return res;
  endfunction

  task automatic load_mem();
    for (int a = 0; a < 256; a++) begin
      bus.wr_en = 1'b1; bus.wr_addr = 8'(a); bus.wr_data = 8'(a);
      @(posedge clk); #1;
      ref_mem[a] = 8'(a);
    end
    bus.wr_en = 1'b0;
  endtask

  // Optional write rides on the acceptance edge; expectations use pre-write memory.
  task automatic do_req(input logic [7:0] idx, input logic dir,
                        input logic wr, input logic [7:0] waddr, input logic [7:0] wdata);
    beat_t e;
    for (int j = 0; j < LINES; j++) begin
      e.pix  = model(idx, dir, j);
      e.last = (j == LINES - 1);
      exp_q.push_back(e);
    end
    chk("pre_req_ready", bus.req_ready, 1'b1);
    bus.req_valid = 1'b1; bus.req_idx = idx; bus.req_dir = dir;
    bus.wr_en = wr; bus.wr_addr = waddr; bus.wr_data = wdata;
    @(posedge clk); #1;
    bus.req_valid = 1'b0; bus.wr_en = 1'b0;
    if (wr) ref_mem[waddr] = wdata;
    chk("accept_latency", bus.out_valid, 1'b1);
  endtask

  task automatic collect(input int max_beats, input int stall_line, input int stall_cycles);
    int beat = 0;
    int budget = 0;
    beat_t e;
    while (exp_q.size() > 0 && beat < max_beats && budget < 64) begin
      budget++;
      if (bus.out_valid !== 1'b1) begin
        @(posedge clk); #1;
      end else begin
        if (beat == stall_line) begin
          bus.out_ready = 1'b0;
          for (int s = 0; s < stall_cycles; s++) begin
            bus.req_valid = 1'b1; bus.req_idx = 8'h00; bus.req_dir = 1'b0;
            @(posedge clk); #1;
            chk("stall_valid", bus.out_valid, 1'b1);
            chk("stall_pix",   bus.out_pix,   exp_q[0].pix);
            chk("stall_last",  bus.out_last,  exp_q[0].last);
            chk("stall_ready", bus.req_ready, 1'b0);
          end
          bus.req_valid = 1'b0; bus.out_ready = 1'b1;
        end
        e = exp_q.pop_front();
        chk($sformatf("pix_line%0d", beat),  bus.out_pix,  e.pix);
        chk($sformatf("last_line%0d", beat), bus.out_last, e.last);
        seen[beat] = bus.out_pix;
        beat++;
        @(posedge clk); #1;
      end
    end
    if (beat < max_beats) chk("beats_drained", exp_q.size(), 0);
  endtask

  task automatic post_idle();
    chk("post_valid", bus.out_valid, 1'b0);
    chk("post_last",  bus.out_last,  1'b0);
    chk("post_ready", bus.req_ready, 1'b1);
  endtask

  initial begin
    rst = 1'b0;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.req_valid = 1'b0; bus.req_idx = '0; bus.req_dir = 1'b0;
    bus.out_ready = 1'b1;
    #12;
    chk("rst_valid", bus.out_valid, 1'b0);
    chk("rst_ready", bus.req_ready, 1'b1);
    chk("rst_pix",   bus.out_pix,   48'h0);
    chk("rst_last",  bus.out_last,  1'b0);
    #5 rst = 1'b1;
    @(posedge clk); #1;

    load_mem();

    // Horizontal from the block centre
    do_req(8'h55, 1'b0, 1'b0, 8'h00, 8'h00);
    collect(99, -1, 0);
    post_idle();
    chk("h_line0", seen[0], 48'h383736353433);
    chk("h_line5", seen[5], 48'h888786858483);

    // Vertical
    do_req(8'h55, 1'b1, 1'b0, 8'h00, 8'h00);
    collect(99, -1, 0);
    post_idle();
    chk("v_line0", seen[0], 48'h837363534333);
    chk("v_line5", seen[5], 48'h887868584838);

    // Corner clamping
    do_req(8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    collect(99, -1, 0);
    chk("clamp_lo_line0", seen[0], 48'h030201000000);
    do_req(8'hFF, 1'b0, 1'b0, 8'h00, 8'h00);
    collect(99, -1, 0);
    chk("clamp_hi_line5", seen[5], 48'hFFFFFFFFFEFD);
    post_idle();

    // Backpressure on line 2 with ignored request pulses
    do_req(8'h37, 1'b1, 1'b0, 8'h00, 8'h00);
    collect(99, 2, 3);
    post_idle();

    // Asynchronous reset while line 3 is presented
    do_req(8'h55, 1'b0, 1'b0, 8'h00, 8'h00);
    collect(3, -1, 0);
    #2 rst = 1'b0;
    #1;
    chk("midrst_valid", bus.out_valid, 1'b0);
    chk("midrst_pix",   bus.out_pix,   48'h0);
    chk("midrst_ready", bus.req_ready, 1'b1);
    chk("midrst_last",  bus.out_last,  1'b0);
    exp_q.delete();
    #1 rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_quiet", bus.out_valid, 1'b0);
    do_req(8'h12, 1'b0, 1'b0, 8'h00, 8'h00);
    collect(99, -1, 0);
    post_idle();

    // Write landing on the acceptance edge
    do_req(8'h55, 1'b0, 1'b1, 8'h33, 8'hAA);
    collect(99, -1, 0);
    chk("coll_old", seen[0][7:0], 8'h33);
    do_req(8'h55, 1'b0, 1'b0, 8'h00, 8'h00);
    collect(99, -1, 0);
    chk("coll_new", seen[0][7:0], 8'hAA);
    post_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
